// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero-extended upper bits leave the result intact.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_n.sv
// Parametrised-depth, parametrised-width flop chain for clock-domain crossing.
module sync_ff_n #(
    parameter int unsigned pWIDTH  = 1,
    parameter int unsigned pSTAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [pWIDTH-1:0] d_i,
    output logic [pWIDTH-1:0] q_o
);

    logic [pWIDTH-1:0] stage_q [pSTAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < pSTAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < pSTAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[pSTAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: pointers, level, full/almost-full.
// Optional sticky overflow flag enabled by defining WR_PTR_CTRL_OVF_EN.
module wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH  = 4,
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst_n,
    input  logic                   wr_push,
    input  logic [pADDR_WIDTH:0]   rd_ptr,
    input  logic [pADDR_WIDTH:0]   wr_afull_thr,
    input  logic                   wr_ovf_clr,
    output logic                   wr_en,
    output logic [pADDR_WIDTH-1:0] wr_addr,
    output logic [pADDR_WIDTH:0]   wr_ptr,
    output logic                   wr_full,
    output logic                   wr_afull,
    output logic [pADDR_WIDTH:0]   wr_level,
    output logic                   wr_ovf
);

    localparam int unsigned PTR_W = pADDR_WIDTH + 1;
    localparam int unsigned DEPTH = fifo_depth(pADDR_WIDTH);

    logic [PTR_W-1:0] wr_bin_q,  wr_bin_d;
    logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] level_q,   level_d;
    logic             full_q,    full_d;
    logic             afull_q,   afull_d;
    logic [PTR_W-1:0] rd_gray_s;
    logic [PTR_W-1:0] rd_bin_s;
    logic             accept_c;

    sync_ff_n #(
        .pWIDTH  (PTR_W),
        .pSTAGES (pSYNC_STAGES)
    ) u_rd_sync (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d_i   (rd_ptr),
        .q_o   (rd_gray_s)
    );

    // Level is computed against the post-push pointer so a push and a read
    // pointer advance landing together cancel in one update.
    always_comb begin
        accept_c  = wr_push & ~full_q;
        wr_bin_d  = wr_bin_q + PTR_W'(accept_c);
        wr_gray_d = PTR_W'(bin2gray(ptr_t'(wr_bin_d)));
        rd_bin_s  = PTR_W'(gray2bin(ptr_t'(rd_gray_s)));
        level_d   = wr_bin_d - rd_bin_s;
        full_d    = (level_d == PTR_W'(DEPTH));
        afull_d   = (level_d >= wr_afull_thr);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
        end
    end

    assign wr_en    = accept_c;
    assign wr_addr  = wr_bin_q[pADDR_WIDTH-1:0];
    assign wr_ptr   = wr_gray_q;
    assign wr_full  = full_q;
    assign wr_afull = afull_q;
    assign wr_level = level_q;

`ifdef WR_PTR_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    // Set has priority over clear so a coincident overflow is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_push && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign wr_ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = wr_ovf_clr;
    assign wr_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Self-checking bench for wr_ptr_ctrl (pADDR_WIDTH=4, pSYNC_STAGES=2) with an occupancy-count reference model.
`timescale 1ns/1ps
module tb_wr_ptr_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = AW + 1;
    localparam int          DEPTH = 16;
    localparam int          MODN  = 32;
`ifdef WR_PTR_CTRL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          wr_clk       = 1'b0;
    logic          wr_rst_n     = 1'b0;
    logic          wr_push      = 1'b0;
    logic          wr_ovf_clr   = 1'b0;
    logic [PW-1:0] wr_afull_thr = '0;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_ptr;
    logic          wr_full;
    logic          wr_afull;
    logic [PW-1:0] wr_level;
    logic          wr_ovf;

    int n_chk = 0;
    int n_err = 0;
    int rd_cnt = 0;

    function automatic logic [PW-1:0] to_gray(input int c);
        logic [PW-1:0] b;
        b = PW'(c % MODN);
        return b ^ (b >> 1);
    endfunction

    assign rd_ptr = to_gray(rd_cnt);

    wr_ptr_ctrl #(.pADDR_WIDTH(AW), .pSYNC_STAGES(2)) dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .wr_push      (wr_push),
        .rd_ptr       (rd_ptr),
        .wr_afull_thr (wr_afull_thr),
        .wr_ovf_clr   (wr_ovf_clr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_ptr       (wr_ptr),
        .wr_full      (wr_full),
        .wr_afull     (wr_afull),
        .wr_level     (wr_level),
        .wr_ovf       (wr_ovf)
    );

    always #5 wr_clk = ~wr_clk;

    // Reference model: unwrapped write/read counts; the write side sees reads two edges late.
    int m_wtot = 0, m_s1 = 0, m_s2 = 0, m_level = 0;
    bit m_full = 0, m_afull = 0, m_ovf = 0;
    always @(posedge wr_clk or negedge wr_rst_n) begin : model
        int nw;
        int lvl;
        if (!wr_rst_n) begin
            m_wtot <= 0; m_s1 <= 0; m_s2 <= 0; m_level <= 0;
            m_full <= 0; m_afull <= 0; m_ovf <= 0;
        end else begin
            nw  = m_wtot + ((wr_push && !m_full) ? 1 : 0);
            lvl = nw - m_s2;
            m_wtot  <= nw;
            m_level <= lvl;
            m_s2    <= m_s1;
            m_s1    <= rd_cnt;
            m_full  <= (lvl == DEPTH);
            m_afull <= (lvl >= int'(wr_afull_thr));
            if (OVF_EN) begin
                if (wr_push && m_full) m_ovf <= 1'b1;
                else if (wr_ovf_clr)   m_ovf <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        wr_rst_n = 0; wr_push = 1; wr_afull_thr = '0; rd_cnt = 0;
        #3;
        tick(); tick();
        n_chk++; if (wr_ptr !== '0)   begin n_err++; $display("FAIL rst_ptr: got %b exp 00000", wr_ptr); end
        n_chk++; if (wr_level !== '0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", wr_level); end
        n_chk++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b exp 0", wr_full); end
        n_chk++; if (wr_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull: got %b exp 0", wr_afull); end
        n_chk++; if (wr_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", wr_ovf); end
        n_chk++; if (wr_addr !== '0)  begin n_err++; $display("FAIL rst_addr: got %0d exp 0", wr_addr); end
        n_chk++; if (wr_en !== 1'b1)  begin n_err++; $display("FAIL rst_en_follow1: got %b exp 1", wr_en); end
        wr_push = 0; #1;
        n_chk++; if (wr_en !== 1'b0)  begin n_err++; $display("FAIL rst_en_follow0: got %b exp 0", wr_en); end
        wr_rst_n = 1;
        tick();
        n_chk++; if (wr_afull !== 1'b1) begin n_err++; $display("FAIL rst_afull_thr0: got %b exp 1", wr_afull); end
        wr_afull_thr = PW'(12);
        tick();
        n_chk++; if (wr_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull_thr12: got %b exp 0", wr_afull); end
    endtask

    task automatic test_fill();
        rd_cnt = 0; wr_afull_thr = PW'(12);
        for (int i = 0; i < 16; i++) begin
            wr_push = 1; #1;
            n_chk++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL fill_en[%0d]: got %b exp 1", i, wr_en); end
            n_chk++; if (wr_addr !== AW'(i)) begin n_err++; $display("FAIL fill_addr[%0d]: got %0d exp %0d", i, wr_addr, i); end
            tick();
            n_chk++; if (wr_level !== PW'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, wr_level, i + 1); end
            n_chk++; if (wr_ptr !== to_gray(i + 1)) begin n_err++; $display("FAIL fill_ptr[%0d]: got %b exp %b", i, wr_ptr, to_gray(i + 1)); end
            n_chk++; if (wr_afull !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b exp %b", i, wr_afull, (i + 1 >= 12)); end
            n_chk++; if (wr_full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d]: got %b exp %b", i, wr_full, (i == 15)); end
        end
        n_chk++; if (wr_ptr !== 5'b11000) begin n_err++; $display("FAIL fill_ptr_final: got %b exp 11000", wr_ptr); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            wr_push = 1; wr_ovf_clr = 0; #1;
            n_chk++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_en[%0d]: got %b exp 0", k, wr_en); end
            tick();
            n_chk++; if (wr_ptr !== 5'b11000) begin n_err++; $display("FAIL ovf_ptr[%0d]: got %b exp 11000", k, wr_ptr); end
            n_chk++; if (wr_level !== PW'(16)) begin n_err++; $display("FAIL ovf_level[%0d]: got %0d exp 16", k, wr_level); end
            n_chk++; if (wr_ovf !== OVF_EN) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b exp %b", k, wr_ovf, OVF_EN); end
        end
        wr_push = 0;
        repeat (3) tick();
        n_chk++; if (wr_ovf !== OVF_EN) begin n_err++; $display("FAIL ovf_sticky: got %b exp %b", wr_ovf, OVF_EN); end
        wr_push = 1; wr_ovf_clr = 1;
        tick();
        n_chk++; if (wr_ovf !== OVF_EN) begin n_err++; $display("FAIL ovf_set_wins: got %b exp %b", wr_ovf, OVF_EN); end
        wr_push = 0;
        tick();
        wr_ovf_clr = 0;
        n_chk++; if (wr_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b exp 0", wr_ovf); end
    endtask

    task automatic test_read_free();
        wr_push = 0; rd_cnt = 1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_chk++; if (wr_full !== (e < 3)) begin n_err++; $display("FAIL free_full[e%0d]: got %b exp %b", e, wr_full, (e < 3)); end
            n_chk++; if (wr_level !== PW'(e < 3 ? 16 : 15)) begin n_err++; $display("FAIL free_level[e%0d]: got %0d exp %0d", e, wr_level, (e < 3 ? 16 : 15)); end
        end
        rd_cnt = 4;
        repeat (3) tick();
        n_chk++; if (wr_level !== PW'(12) || wr_afull !== 1'b1) begin n_err++; $display("FAIL free_afull12: got level %0d afull %b exp 12/1", wr_level, wr_afull); end
        rd_cnt = 5;
        repeat (2) tick();
        n_chk++; if (wr_afull !== 1'b1) begin n_err++; $display("FAIL free_afull_lag: got %b exp 1", wr_afull); end
        tick();
        n_chk++; if (wr_level !== PW'(11) || wr_afull !== 1'b0) begin n_err++; $display("FAIL free_afull11: got level %0d afull %b exp 11/0", wr_level, wr_afull); end
        rd_cnt = 16;
        repeat (3) tick();
        n_chk++; if (wr_level !== '0) begin n_err++; $display("FAIL free_drain: got %0d exp 0", wr_level); end
    endtask

    task automatic test_tracking();
        int max_lvl;
        wr_push = 0; #2; wr_rst_n = 0; rd_cnt = 0; #2; wr_rst_n = 1;
        tick();
        max_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            wr_push = 1; rd_cnt = m_wtot;
            tick();
            if (int'(wr_level) > max_lvl) max_lvl = int'(wr_level);
            n_chk++; if (wr_level !== PW'(m_level) || wr_full !== 1'b0 || wr_ptr !== to_gray(m_wtot) || wr_addr !== AW'(m_wtot % DEPTH)) begin
                n_err++; $display("FAIL track[%0d]: got lvl %0d full %b ptr %b addr %0d exp lvl %0d full 0 ptr %b addr %0d",
                                  i, wr_level, wr_full, wr_ptr, wr_addr, m_level, to_gray(m_wtot), m_wtot % DEPTH);
            end
        end
        n_chk++; if (max_lvl > 3) begin n_err++; $display("FAIL track_maxlevel: got %0d exp <=3", max_lvl); end
        n_chk++; if (wr_ptr !== to_gray(40)) begin n_err++; $display("FAIL track_wrap_ptr: got %b exp %b", wr_ptr, to_gray(40)); end
    endtask

    task automatic test_random();
        wr_afull_thr = PW'($urandom_range(0, 20));
        for (int i = 0; i < 400; i++) begin
            wr_push    = ($urandom_range(0, 3) != 0);
            wr_ovf_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0 && rd_cnt < m_wtot) rd_cnt++;
            #1;
            n_chk++; if (wr_en !== (wr_push && !m_full)) begin n_err++; $display("FAIL rand_en[%0d]: got %b exp %b", i, wr_en, (wr_push && !m_full)); end
            tick();
            n_chk++; if (wr_level !== PW'(m_level) || wr_full !== m_full || wr_afull !== m_afull ||
                         wr_ptr !== to_gray(m_wtot) || wr_addr !== AW'(m_wtot % DEPTH) || wr_ovf !== m_ovf) begin
                n_err++; $display("FAIL rand[%0d]: got lvl %0d full %b afull %b ptr %b addr %0d ovf %b exp lvl %0d full %b afull %b ptr %b addr %0d ovf %b",
                                  i, wr_level, wr_full, wr_afull, wr_ptr, wr_addr, wr_ovf,
                                  m_level, m_full, m_afull, to_gray(m_wtot), m_wtot % DEPTH, m_ovf);
            end
        end
        wr_ovf_clr = 0;
    endtask

    task automatic test_mid_reset();
        wr_push = 0; wr_rst_n = 0; rd_cnt = 0; wr_afull_thr = PW'(12); #2; wr_rst_n = 1;
        tick();
        repeat (7) begin wr_push = 1; tick(); end
        n_chk++; if (wr_level !== PW'(7)) begin n_err++; $display("FAIL mid_pre_level: got %0d exp 7", wr_level); end
        #2; wr_rst_n = 0; #1;
        n_chk++; if (wr_ptr !== '0 || wr_level !== '0 || wr_full !== 1'b0 || wr_afull !== 1'b0 || wr_addr !== '0 || wr_ovf !== 1'b0 || wr_en !== 1'b1) begin
            n_err++; $display("FAIL mid_async_reset: got ptr %b lvl %0d full %b afull %b addr %0d ovf %b en %b exp 0/0/0/0/0/0/1",
                              wr_ptr, wr_level, wr_full, wr_afull, wr_addr, wr_ovf, wr_en);
        end
        tick();
        wr_rst_n = 1; wr_push = 1; #1;
        n_chk++; if (wr_addr !== '0 || wr_en !== 1'b1) begin n_err++; $display("FAIL mid_first_push: got addr %0d en %b exp 0/1", wr_addr, wr_en); end
        tick();
        n_chk++; if (wr_addr !== AW'(1) || wr_level !== PW'(1)) begin n_err++; $display("FAIL mid_after_push: got addr %0d lvl %0d exp 1/1", wr_addr, wr_level); end
        wr_push = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_free();
        test_tracking();
        test_random();
        test_mid_reset();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wr_ptr_ctrl.md
# wr_ptr_ctrl

Write-domain pointer controller for the asynchronous FIFO, the parametrised successor to the basic write control logic. It owns the binary/Gray write pointer and synchronises the read-domain Gray pointer internally. It also derives a registered fill level, full flag and programmable almost-full flag, and can optionally flag overflow attempts. It sits in the write clock domain between the producer and the dual-port RAM, and exports its Gray pointer to the read-side controller.

## Interface
- pADDR_WIDTH, 4: RAM address width; depth DEPTH = 2**pADDR_WIDTH; pointers are pADDR_WIDTH+1 bits.
- pSYNC_STAGES, 2: flop stages in the rd_ptr synchroniser; legal range 2..4.
- wr_clk  in  1  write clock; the only clock in the block.
- wr_rst_n  in  1  asynchronous, active-low reset.
- wr_push  in  1  producer write request.
- rd_ptr  in  pADDR_WIDTH+1  Gray read pointer from the read domain; unsynchronised.
- wr_afull_thr  in  pADDR_WIDTH+1  almost-full threshold in words; quasi-static.
- wr_ovf_clr  in  1  clears sticky overflow flag.
- wr_en  out  1  RAM write enable = wr_push & ~wr_full (combinational).
- wr_addr  out  pADDR_WIDTH  RAM write address = wr_bin[pADDR_WIDTH-1:0].
- wr_ptr  out  pADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wr_full  out  1  registered full flag.
- wr_afull  out  1  registered almost-full flag.
- wr_level  out  pADDR_WIDTH+1  registered fill level, 0..DEPTH.
- wr_ovf  out  1  sticky overflow flag.

## Operation
- Push is accepted iff wr_push && !wr_full. wr_bin_nxt = wr_bin + accept. wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1).
- rd_ptr passes through pSYNC_STAGES flops to give rd_gray_s. rd_gray_s is converted Gray→binary to give rd_bin_s (XOR prefix from MSB).
- level_nxt = wr_bin_nxt − rd_bin_s, modulo 2**(pADDR_WIDTH+1). The result is always 0..DEPTH.
- wr_full ← (level_nxt == DEPTH). This is equivalent to Gray-comparing against rd_gray_s with the top two bits inverted.
- wr_afull ← (level_nxt >= wr_afull_thr). A threshold of 0 forces wr_afull=1. A threshold above DEPTH means wr_afull never asserts.
- wr_level ← level_nxt.
- Level is pessimistic: it may overstate occupancy by up to the synchroniser lag. It never understates it, so no write overruns unread data.
- Push while full: wr_en=0, and pointers and RAM are unchanged.
- Wrap-around: wr_bin rolls from 2**(pADDR_WIDTH+1)−1 to 0. The extra MSB distinguishes full from empty.
- Reset mid-operation clears all state immediately, including the synchroniser flops. The read side must be reset in the same event.

## Timing
- Reset values: wr_ptr=0, wr_full=0, wr_afull=(wr_afull_thr==0) after the first clock and 0 during reset, wr_level=0, wr_ovf=0. wr_addr=0 during reset. wr_en follows wr_push while reset is held.
- Write latency: an accepted push at edge N updates wr_addr, wr_ptr, wr_level and flags at edge N, visible in cycle N+1.
- wr_full asserts in the cycle after the push that filled the FIFO. No accepted push can occur while it is high.
- Read-side freeing: a change on rd_ptr reaches wr_level/wr_full/wr_afull after pSYNC_STAGES+1 wr_clk edges.
- Simultaneous push and synchronised read pointer advance: the level reflects both in the same update; net level change is 0.
- wr_ptr changes at most one bit per wr_clk, which makes it safe to synchronise.

## Configuration
- WR_PTR_CTRL_OVF_EN defined: wr_ovf sets on any cycle with wr_push && wr_full and stays set until wr_ovf_clr or reset. If set and clear occur in the same cycle, set wins.
- WR_PTR_CTRL_OVF_EN undefined: wr_ovf is tied 0 and wr_ovf_clr is ignored. The port list is identical in both builds.

## Structure
- Shared package fifo_pkg: bin2gray and gray2bin functions, and the DEPTH derivation from the address width. The same package is reused by the read-side controller.
- One sub-module: sync_ff_n. It is a pSYNC_STAGES-deep, parametrised-width flop chain with async active-low reset, instantiated for rd_ptr.

## Test plan
- Reset then 16 pushes with rd_ptr=0 (pADDR_WIDTH=4). Required: wr_level 1..16; wr_full=1 in the cycle after the 16th; wr_addr steps 0..15; wr_ptr follows Gray 00000→11000.
- When full, 3 more pushes. Required: wr_en=0, wr_ptr unchanged; with OVF_EN, wr_ovf=1 and it stays set until wr_ovf_clr.
- When full, drive rd_ptr Gray to 00001 (one word read). Required: wr_full=0 and wr_level=15 exactly 3 wr_clk edges later (pSYNC_STAGES=2).
- wr_afull_thr=12, pushing from empty. Required: wr_afull rises in the cycle after the 12th push; it falls once the synchronised level drops to 11.
- Continuous push with rd_ptr tracking the write pointer through 40 writes. Required: correct wrap from wr_bin 31→0, wr_full never asserts, wr_level ≤ 3.
- Assert wr_rst_n low mid-burst at level 7. Required: all outputs return to reset values asynchronously; after release, the first push writes wr_addr=0.
